// File: rtl/usbf_crc16_seq.sv
// USB CRC16 packet sequencer: TX passes payload through and appends the CRC16,
// RX consumes payload+CRC and checks the residue; both report length/CRC status.

module usbf_crc16 (
    input  logic [15:0] crc_in,
    input  logic [7:0]  din,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    // Polynomial x^16+x^15+x^2+1, data bits taken LSB first (USB wire order).
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ din[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end
endmodule

module usbf_crc16_seq #(
    parameter int unsigned MAX_LEN = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        done,
    output logic        crc_ok,
    output logic        len_err,
    output logic [10:0] byte_cnt
);
    localparam logic [11:0] LEN_TX_MAX = 12'(MAX_LEN);
    localparam logic [11:0] LEN_RX_MAX = 12'(MAX_LEN + 2);
    localparam logic [15:0] CRC_SEED   = 16'hFFFF;
    localparam logic [15:0] CRC_RESID  = 16'h800D;

    typedef enum logic [2:0] {IDLE, DATA, CRC1, CRC2, STAT} state_t;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        crc_ok_q, crc_ok_d;
    logic        len_err_q, len_err_d;
    logic        done_q, done_d;
    logic        run_q;

    logic        eff_mode;
    logic        xfer;
    logic [15:0] crc_seed;
    logic [15:0] crc_step;

    // A new packet takes mode and CRC seed straight from the inputs while in IDLE.
    assign eff_mode = (state_q == IDLE) ? mode : mode_q;
    assign crc_seed = (state_q == IDLE) ? CRC_SEED : crc_q;

    usbf_crc16 u_crc (
        .crc_in  (crc_seed),
        .din     (in_data),
        .crc_out (crc_step)
    );

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        crc_ok_d  = crc_ok_q;
        len_err_d = len_err_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        xfer      = 1'b0;

        case (state_q)
            IDLE, DATA: begin
                in_ready = run_q & (eff_mode | out_ready);
                if (!eff_mode) begin
                    out_valid = run_q & in_valid;
                    out_data  = run_q ? in_data : 8'h00;
                end
                xfer = in_valid & in_ready;
                if (xfer) begin
                    crc_d  = crc_step;
                    mode_d = eff_mode;
                    if (state_q == IDLE)      cnt_d = 11'd1;
                    else if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
                    if (in_last) state_d = eff_mode ? STAT : CRC1;
                    else         state_d = DATA;
                end
            end
            CRC1: begin
                out_valid = 1'b1;
                out_data  = ~{crc_q[8], crc_q[9], crc_q[10], crc_q[11],
                              crc_q[12], crc_q[13], crc_q[14], crc_q[15]};
                if (out_ready) state_d = CRC2;
            end
            CRC2: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = ~{crc_q[0], crc_q[1], crc_q[2], crc_q[3],
                              crc_q[4], crc_q[5], crc_q[6], crc_q[7]};
                if (out_ready) state_d = STAT;
            end
            STAT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status is captured on entry to STAT so it lines up with the done pulse.
        if (state_d == STAT) begin
            done_d = 1'b1;
            if (mode_d) len_err_d = ({1'b0, cnt_d} < 12'd2) || ({1'b0, cnt_d} > LEN_RX_MAX);
            else        len_err_d = {1'b0, cnt_d} > LEN_TX_MAX;
            if (len_err_d)   crc_ok_d = 1'b0;
            else if (mode_d) crc_ok_d = (crc_d == CRC_RESID);
            else             crc_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            crc_q     <= CRC_SEED;
            cnt_q     <= 11'd0;
            mode_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            len_err_q <= 1'b0;
            done_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            crc_ok_q  <= crc_ok_d;
            len_err_q <= len_err_d;
            done_q    <= done_d;
            run_q     <= 1'b1;
        end
    end

    assign done     = done_q;
    assign crc_ok   = crc_ok_q;
    assign len_err  = len_err_q;
    assign byte_cnt = cnt_q;
endmodule
